fifo_wr_arbiter: RTL and testbench

Round-robin, packet-aware arbiter that shares the write port of the dual-clock FIFO between several valid/ready producers in the write-clock domain. It picks one requester, holds the grant for a packet or a bounded burst, and drives the FIFO `wr_en`/`data_in` from the granted source. Its FIFO-side ports connect directly to `wr_en`, `data_in` and `full` of `generic_fifo_dc`. It contains a 2-state FSM, a grant register, a round-robin pointer and a beat counter.

---
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing the dual-clock FIFO write port
// between several valid/ready producers in the write-clock domain.
module fifo_wr_arbiter #(
  parameter int unsigned n_req     = 4,
  parameter int unsigned id_size   = 2,
  parameter int unsigned data_size = 8,
  parameter int unsigned max_burst = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [n_req-1:0]              req_valid,
  input  logic [n_req-1:0]              req_last,
  input  logic [n_req*data_size-1:0]    req_data,
  output logic [n_req-1:0]              req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [data_size-1:0]          fifo_data,
  output logic [id_size-1:0]            grant_id,
  output logic                          busy
);

  localparam int unsigned cnt_w = 4;
  localparam logic [cnt_w-1:0] beat_max = cnt_w'(max_burst - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [id_size-1:0]   grant_q, grant_d;
  logic [id_size-1:0]   last_q, last_d;
  logic [cnt_w-1:0]     beat_q, beat_d;

  logic                 g_valid, g_last;
  logic [data_size-1:0] g_data;
  logic                 beat_c;
  logic                 hi_found, lo_found;
  logic [id_size-1:0]   hi_pick, lo_pick;

  // State register
  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= id_size'(n_req - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Mux out the currently granted source
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (grant_q == id_size'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*data_size +: data_size];
      end
    end
  end

  assign beat_c = (state_q == BURST) && g_valid && !fifo_full;

  // Round-robin search: lowest index above last_q wins, else wrap to lowest overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = int'(n_req) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (id_size'(i) > last_q) begin
          hi_found = 1'b1;
          hi_pick  = id_size'(i);
        end else begin
          lo_found = 1'b1;
          lo_pick  = id_size'(i);
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (hi_found || lo_found) begin
          grant_d = hi_found ? hi_pick : lo_pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat_c) begin
          beat_d = beat_q + cnt_w'(1);
          if (g_last || (beat_q == beat_max)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: only the granted source sees ready, data is zero outside a burst
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    if (state_q == BURST) begin
      fifo_wr_en = beat_c;
      fifo_data  = g_data;
      for (int unsigned i = 0; i < n_req; i++) begin
        req_ready[i] = (grant_q == id_size'(i)) && !fifo_full;
      end
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues feed the arbiter and a
// write log records every FIFO write for comparison against hand-built lists.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic            wr_clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  logic [8:0]      src_q [N][$];
  logic [N-1:0]    hold_mask;
  logic [9:0]      wlog[$];
  int              wcyc[$];
  int              cyc;
  int              n_tests, n_fail;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.n_req(4), .id_size(2), .data_size(8), .max_burst(4)) dut (
    .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold_mask[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = src_q[i][0][8];
        req_data[i*DW +: DW]  = src_q[i][0][7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    hs = req_valid & req_ready;
    if (fifo_wr_en) begin
      wlog.push_back({grant_id, fifo_data});
      wcyc.push_back(cyc);
    end
    @(posedge wr_clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
    drive_srcs(); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; fifo_full = 1'b0; hold_mask = '0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive_srcs();
    @(posedge wr_clk); #1;
    rst = 1'b1;
    wlog.delete(); wcyc.delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 8'(8'hF0 + i)});
    drive_srcs(); #3;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_tests++; if (fifo_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", fifo_data); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    @(posedge wr_clk); @(posedge wr_clk); #1;
    n_tests++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_hold: busy %b wr_en %b want 0 0", busy, fifo_wr_en); end
    do_reset();
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [7:0] exp_d[3];
    exp_d = '{8'hAA, 8'hBB, 8'hCC};
    do_reset();
    src_q[0].push_back(9'h0AA); src_q[0].push_back(9'h0BB); src_q[0].push_back(9'h1CC);
    drive_srcs(); #1;
    n_tests++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_arb_cycle: busy %b wr_en %b want 0 0", busy, fifo_wr_en); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant[%0d]: busy %b grant %0d want 1 0", k, busy, grant_id); end
      n_tests++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_wr[%0d]: wr_en %b ready %b want 1 0001", k, fifo_wr_en, req_ready); end
      n_tests++; if (fifo_data !== exp_d[k]) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", k, fifo_data, exp_d[k]); end
    end
    tick();
    n_tests++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_end: busy %b wr_en %b want 0 0", busy, fifo_wr_en); end
    n_tests++; if (wlog.size() !== 3) begin n_fail++; $display("FAIL single_count: got %0d want 3", wlog.size()); end
  endtask

  task automatic test_round_robin();
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) src_q[i].push_back({1'b1, 8'(16*i + k)});
    drive_srcs(); #1;
    for (int k = 0; k < 40 && wlog.size() < 8; k++) tick();
    n_tests++; if (wlog.size() !== 8) begin n_fail++; $display("FAIL rr_count: got %0d want 8", wlog.size()); end
    for (int j = 0; j < 8 && j < wlog.size(); j++) begin
      e = {2'(j % 4), 8'(16*(j % 4) + j / 4)};
      n_tests++; if (wlog[j] !== e) begin n_fail++; $display("FAIL rr_write[%0d]: got %h want %h", j, wlog[j], e); end
      if (j > 0) begin
        n_tests++; if (wcyc[j] - wcyc[j-1] !== 2) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d want 2", j, wcyc[j] - wcyc[j-1]); end
      end
    end
  endtask

  task automatic test_burst();
    logic [9:0] exp_w[$];
    int         exp_g[$];
    do_reset();
    src_q[0].push_back(9'h1A0);
    for (int k = 0; k < 10; k++) src_q[2].push_back({1'b0, 8'(8'h20 + k)});
    src_q[3].push_back(9'h1B3); src_q[3].push_back(9'h1B4);
    exp_w.push_back({2'd0, 8'hA0}); exp_g.push_back(0);
    for (int k = 0; k < 4; k++) begin exp_w.push_back({2'd2, 8'(8'h20 + k)}); exp_g.push_back(k == 0 ? 2 : 1); end
    exp_w.push_back({2'd3, 8'hB3}); exp_g.push_back(2);
    for (int k = 4; k < 8; k++) begin exp_w.push_back({2'd2, 8'(8'h20 + k)}); exp_g.push_back(k == 4 ? 2 : 1); end
    exp_w.push_back({2'd3, 8'hB4}); exp_g.push_back(2);
    exp_w.push_back({2'd2, 8'h28}); exp_g.push_back(2);
    exp_w.push_back({2'd2, 8'h29}); exp_g.push_back(1);
    drive_srcs(); #1;
    for (int k = 0; k < 60 && wlog.size() < 13; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    n_tests++; if (wlog.size() !== 13) begin n_fail++; $display("FAIL burst_count: got %0d want 13", wlog.size()); end
    for (int j = 0; j < 13 && j < wlog.size(); j++) begin
      n_tests++; if (wlog[j] !== exp_w[j]) begin n_fail++; $display("FAIL burst_write[%0d]: got %h want %h", j, wlog[j], exp_w[j]); end
      if (j > 0) begin
        n_tests++; if (wcyc[j] - wcyc[j-1] !== exp_g[j]) begin n_fail++; $display("FAIL burst_gap[%0d]: got %0d want %0d", j, wcyc[j] - wcyc[j-1], exp_g[j]); end
      end
    end
    n_tests++; if (busy !== 1'b1 || grant_id !== 2'd2 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL burst_held: busy %b grant %0d wr_en %b want 1 2 0", busy, grant_id, fifo_wr_en); end
  endtask

  task automatic test_full();
    int exp_g[6];
    exp_g = '{0, 1, 6, 1, 2, 1};
    do_reset();
    for (int k = 0; k < 6; k++) src_q[1].push_back({k == 5, 8'(8'h40 + k)});
    drive_srcs(); #1;
    tick(); tick(); tick();
    fifo_full = 1'b1; #1;
    for (int f = 0; f < 5; f++) begin
      n_tests++; if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL full_stall[%0d]: ready %b wr_en %b want 0000 0", f, req_ready, fifo_wr_en); end
      n_tests++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL full_hold[%0d]: busy %b grant %0d want 1 1", f, busy, grant_id); end
      tick();
    end
    fifo_full = 1'b0; #1;
    for (int k = 0; k < 30 && wlog.size() < 6; k++) tick();
    n_tests++; if (wlog.size() !== 6) begin n_fail++; $display("FAIL full_count: got %0d want 6", wlog.size()); end
    for (int j = 0; j < 6 && j < wlog.size(); j++) begin
      n_tests++; if (wlog[j] !== {2'd1, 8'(8'h40 + j)}) begin n_fail++; $display("FAIL full_write[%0d]: got %h want %h", j, wlog[j], {2'd1, 8'(8'h40 + j)}); end
      if (j > 0) begin
        n_tests++; if (wcyc[j] - wcyc[j-1] !== exp_g[j]) begin n_fail++; $display("FAIL full_gap[%0d]: got %0d want %0d", j, wcyc[j] - wcyc[j-1], exp_g[j]); end
      end
    end
  endtask

  task automatic test_drop();
    logic [9:0] exp_w[5];
    exp_w = '{{2'd0, 8'h50}, {2'd0, 8'h51}, {2'd0, 8'h52}, {2'd0, 8'h53}, {2'd1, 8'h60}};
    do_reset();
    src_q[0].push_back(9'h050); src_q[0].push_back(9'h051);
    src_q[0].push_back(9'h052); src_q[0].push_back(9'h153);
    src_q[1].push_back(9'h160);
    drive_srcs(); #1;
    tick(); tick(); tick();
    hold_mask = 4'b0001; drive_srcs(); #1;
    for (int h = 0; h < 3; h++) begin
      n_tests++; if (grant_id !== 2'd0 || busy !== 1'b1 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL drop_hold[%0d]: grant %0d busy %b wr_en %b want 0 1 0", h, grant_id, busy, fifo_wr_en); end
      n_tests++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL drop_ready1[%0d]: got %b want 0", h, req_ready[1]); end
      tick();
    end
    hold_mask = '0; drive_srcs(); #1;
    for (int k = 0; k < 20 && wlog.size() < 5; k++) tick();
    n_tests++; if (wlog.size() !== 5) begin n_fail++; $display("FAIL drop_count: got %0d want 5", wlog.size()); end
    for (int j = 0; j < 5 && j < wlog.size(); j++) begin
      n_tests++; if (wlog[j] !== exp_w[j]) begin n_fail++; $display("FAIL drop_write[%0d]: got %h want %h", j, wlog[j], exp_w[j]); end
    end
    if (wlog.size() > 2) begin
      n_tests++; if (wcyc[2] - wcyc[1] !== 4) begin n_fail++; $display("FAIL drop_gap: got %0d want 4", wcyc[2] - wcyc[1]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_q[3].push_back(9'h070); src_q[3].push_back(9'h071); src_q[3].push_back(9'h172);
    drive_srcs(); #1;
    tick(); tick();
    n_tests++; if (busy !== 1'b1 || grant_id !== 2'd3) begin n_fail++; $display("FAIL rstmid_pre: busy %b grant %0d want 1 3", busy, grant_id); end
    #1 rst = 1'b0; #1;
    n_tests++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: busy %b wr_en %b want 0 0", busy, fifo_wr_en); end
    n_tests++; if (req_ready !== 4'b0000 || fifo_data !== 8'h00 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_outs: ready %b data %h grant %0d want 0000 00 0", req_ready, fifo_data, grant_id); end
    for (int i = 0; i < N; i++) src_q[i].delete();
    src_q[0].push_back(9'h180); src_q[3].push_back(9'h190);
    drive_srcs();
    @(posedge wr_clk); #1;
    rst = 1'b1; wlog.delete(); wcyc.delete(); #1;
    for (int k = 0; k < 20 && wlog.size() < 2; k++) tick();
    n_tests++; if (wlog.size() !== 2) begin n_fail++; $display("FAIL rstmid_count: got %0d want 2", wlog.size()); end
    if (wlog.size() > 1) begin
      n_tests++; if (wlog[0] !== {2'd0, 8'h80}) begin n_fail++; $display("FAIL rstmid_first: got %h want 080", wlog[0]); end
      n_tests++; if (wlog[1] !== {2'd3, 8'h90}) begin n_fail++; $display("FAIL rstmid_second: got %h want 390", wlog[1]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b0; fifo_full = 1'b0; hold_mask = '0;
    req_data = '0; req_valid = '0; req_last = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_full();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
